// File: rtl/rv32i_pkg.sv
// rv32i_pkg
//  Shared types and constants for the RV32I front end.
//  fetch_state_t : fetch FSM states (request, wait for response, hold output)
//  RESET_PC_DEFAULT : address the core starts fetching from after reset
//  INST_NOP      : canonical NOP (addi x0, x0, 0) used as the idle buffer value
package rv32i_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0100_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if
//  Bundles the handshake buses around the fetch unit.
//  imem_req_*  : fetch request to instruction memory (valid/ready, address)
//  imem_rsp_*  : instruction memory read data (one response per accepted request)
//  redirect_*  : control-flow redirect pulse from execute
//  inst_*      : buffered instruction presented to decode (valid/ready)
//  modport master : the fetch unit's view
//  modport slave  : the view of memory, execute and decode around it
interface fetch_unit_if #(
    parameter int XLEN = 32
);

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready
    );

endinterface

// File: rtl/fetch_unit.sv
// fetch_unit
//  Fetches one RV32I instruction per PC with a single outstanding memory
//  request and hands it to decode through a one-entry output buffer.
//  Drives the external pc register (next_pc) and reads its output (current_pc).
//  Ports:
//   clk, reset    : clock and synchronous active-high reset
//   current_pc    : pc register output, also the fetch address
//   next_pc       : pc register input, combinational
//   bus           : fetch_unit_if.master (imem request/response, redirect, decode)
//   misalign_err  : one-cycle pulse the cycle after a redirect to a non-word target
module fetch_unit
    import rv32i_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] current_pc,
    output logic [XLEN-1:0] next_pc,
    fetch_unit_if.master    bus,
    output logic            misalign_err
);

    fetch_state_t    state_q, state_d;
    logic            kill_q, kill_d;
    logic            inst_valid_q, inst_valid_d;
    logic [XLEN-1:0] inst_data_q, inst_data_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            misalign_err_q, misalign_err_d;
    logic            advance;

    // A response only moves the PC forward when it is a live (not killed) one.
    assign advance = (state_q == S_WAIT) && bus.imem_rsp_valid && !kill_q;

    // Redirect wins over sequential advance; the target is forced word-aligned.
    always_comb begin
        next_pc = current_pc;
        if (reset) begin
            next_pc = RESET_PC;
        end else if (bus.redirect_valid) begin
            next_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};
        end else if (advance) begin
            next_pc = current_pc + XLEN'(4);
        end
    end

    // Request depends only on state, so memory and decode handshakes never
    // feed back combinationally into imem_req_valid.
    assign bus.imem_req_valid = (state_q == S_REQ) && !reset;
    assign bus.imem_req_addr  = current_pc;
    assign bus.inst_valid     = inst_valid_q;
    assign bus.inst_data      = inst_data_q;
    assign bus.inst_pc        = inst_pc_q;
    assign misalign_err       = misalign_err_q;

    // Next-state logic. A redirect always empties the output buffer; a request
    // that is already in flight (or accepted this cycle) is marked for killing
    // so its response is dropped instead of reaching decode.
    always_comb begin
        state_d        = state_q;
        kill_d         = kill_q;
        inst_valid_d   = inst_valid_q;
        inst_data_d    = inst_data_q;
        inst_pc_d      = inst_pc_q;
        misalign_err_d = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);

        case (state_q)
            S_REQ: begin
                if (bus.imem_req_ready) begin
                    state_d = S_WAIT;
                    if (bus.redirect_valid) begin
                        kill_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    state_d = S_REQ;
                    kill_d  = 1'b0;
                    if (!kill_q && !bus.redirect_valid) begin
                        inst_data_d  = bus.imem_rsp_data;
                        inst_pc_d    = current_pc;
                        inst_valid_d = 1'b1;
                        state_d      = S_HOLD;
                    end
                end else if (bus.redirect_valid) begin
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (bus.redirect_valid || bus.inst_ready) begin
                    inst_valid_d = 1'b0;
                    state_d      = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        if (bus.redirect_valid) begin
            inst_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_REQ;
            kill_q         <= 1'b0;
            inst_valid_q   <= 1'b0;
            inst_data_q    <= INST_NOP;
            inst_pc_q      <= '0;
            misalign_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            kill_q         <= kill_d;
            inst_valid_q   <= inst_valid_d;
            inst_data_q    <= inst_data_d;
            inst_pc_q      <= inst_pc_d;
            misalign_err_q <= misalign_err_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//  Directed bench: pc register + fetch_unit + behavioural instruction memory.
//  The memory returns (address + 32'h1000_0000) as the instruction word, with
//  a programmable response latency and a programmable number of ready-low
//  cycles before each request is accepted.
module tb_fetch_unit;
    import rv32i_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] current_pc;
    logic [31:0] next_pc;
    logic        misalign_err;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_unit_if #(.XLEN(32)) bus ();

    fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .current_pc   (current_pc),
        .next_pc      (next_pc),
        .bus          (bus),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    // External pc register loads next_pc every cycle.
    always @(posedge clk) current_pc <= next_pc;

    // Behavioural instruction memory.
    int          mem_lat       = 1;
    int          mem_stall_cfg = 0;
    int          stall_cnt     = 0;
    int          remaining     = 0;
    logic        mem_busy      = 1'b0;
    logic [31:0] mem_addr      = 32'h0;

    assign bus.imem_req_ready = (stall_cnt >= mem_stall_cfg);
    assign bus.imem_rsp_valid = mem_busy && (remaining == 1);
    assign bus.imem_rsp_data  = mem_addr + 32'h1000_0000;

    always @(posedge clk) begin
        if (reset) begin
            mem_busy  <= 1'b0;
            stall_cnt <= 0;
            remaining <= 0;
        end else if (bus.imem_req_valid && bus.imem_req_ready) begin
            mem_busy  <= 1'b1;
            remaining <= mem_lat;
            mem_addr  <= bus.imem_req_addr;
            stall_cnt <= 0;
        end else begin
            if (bus.imem_req_valid) stall_cnt <= stall_cnt + 1;
            if (mem_busy) begin
                if (remaining == 1) mem_busy <= 1'b0;
                remaining <= remaining - 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.inst_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        tick();
        n_checks++; if (bus.inst_valid !== 1'b0) $display("[TB] FAIL rst_inst_valid: got %b want 0", bus.inst_valid); else n_pass++;
        n_checks++; if (bus.inst_data !== 32'h0000_0013) $display("[TB] FAIL rst_inst_data: got %h want 00000013", bus.inst_data); else n_pass++;
        n_checks++; if (bus.inst_pc !== 32'h0) $display("[TB] FAIL rst_inst_pc: got %h want 00000000", bus.inst_pc); else n_pass++;
        n_checks++; if (misalign_err !== 1'b0) $display("[TB] FAIL rst_misalign: got %b want 0", misalign_err); else n_pass++;
        n_checks++; if (bus.imem_req_valid !== 1'b0) $display("[TB] FAIL rst_req_valid: got %b want 0", bus.imem_req_valid); else n_pass++;
        n_checks++; if (next_pc !== 32'h0100_0000) $display("[TB] FAIL rst_next_pc: got %h want 01000000", next_pc); else n_pass++;
        tick();
        reset = 1'b0;
        bus.inst_ready = 1'b1;
        #1;
        n_checks++; if (current_pc !== 32'h0100_0000) $display("[TB] FAIL rel_current_pc: got %h want 01000000", current_pc); else n_pass++;
        n_checks++; if (bus.imem_req_valid !== 1'b1) $display("[TB] FAIL rel_req_valid: got %b want 1", bus.imem_req_valid); else n_pass++;
        n_checks++; if (bus.imem_req_addr !== 32'h0100_0000) $display("[TB] FAIL rel_req_addr: got %h want 01000000", bus.imem_req_addr); else n_pass++;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [3];
        logic [31:0] exp_data [3];
        int got;
        int k;
        exp_pc[0] = 32'h0100_0000; exp_data[0] = 32'h1100_0000;
        exp_pc[1] = 32'h0100_0004; exp_data[1] = 32'h1100_0004;
        exp_pc[2] = 32'h0100_0008; exp_data[2] = 32'h1100_0008;
        got = 0;
        k = 0;
        while (got < 3 && k < 40) begin
            if (bus.inst_valid && bus.inst_ready) begin
                n_checks++; if (bus.inst_pc !== exp_pc[got]) $display("[TB] FAIL seq_pc%0d: got %h want %h", got, bus.inst_pc, exp_pc[got]); else n_pass++;
                n_checks++; if (bus.inst_data !== exp_data[got]) $display("[TB] FAIL seq_data%0d: got %h want %h", got, bus.inst_data, exp_data[got]); else n_pass++;
                got++;
            end
            if (got < 3) begin
                tick();
                k++;
            end
        end
        n_checks++; if (got !== 3) $display("[TB] FAIL seq_count: got %0d want 3", got); else n_pass++;
        tick();
    endtask

    task automatic test_latency();
        int k;
        mem_lat = 3;
        mem_stall_cfg = 2;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (bus.imem_req_valid !== 1'b1) $display("[TB] FAIL stall_req_valid%0d: got %b want 1", i, bus.imem_req_valid); else n_pass++;
            n_checks++; if (bus.imem_req_addr !== 32'h0100_000C) $display("[TB] FAIL stall_req_addr%0d: got %h want 0100000c", i, bus.imem_req_addr); else n_pass++;
            n_checks++; if (bus.imem_req_ready !== 1'b0) $display("[TB] FAIL stall_ready%0d: got %b want 0", i, bus.imem_req_ready); else n_pass++;
            tick();
        end
        n_checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_ready !== 1'b1) $display("[TB] FAIL accept: got valid=%b ready=%b want 1/1", bus.imem_req_valid, bus.imem_req_ready); else n_pass++;
        n_checks++; if (bus.imem_req_addr !== 32'h0100_000C) $display("[TB] FAIL accept_addr: got %h want 0100000c", bus.imem_req_addr); else n_pass++;
        k = 0;
        do begin
            tick();
            mem_stall_cfg = 0;
            k++;
        end while (!bus.inst_valid && k < 20);
        n_checks++; if (k !== 4) $display("[TB] FAIL latency: got %0d cycles want 4", k); else n_pass++;
        n_checks++; if (bus.inst_pc !== 32'h0100_000C) $display("[TB] FAIL lat_pc: got %h want 0100000c", bus.inst_pc); else n_pass++;
        n_checks++; if (bus.inst_data !== 32'h1100_000C) $display("[TB] FAIL lat_data: got %h want 1100000c", bus.inst_data); else n_pass++;
        bus.inst_ready = 1'b0;
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (bus.inst_valid !== 1'b1) $display("[TB] FAIL hold_valid%0d: got %b want 1", i, bus.inst_valid); else n_pass++;
            n_checks++; if (bus.inst_pc !== 32'h0100_000C) $display("[TB] FAIL hold_pc%0d: got %h want 0100000c", i, bus.inst_pc); else n_pass++;
            n_checks++; if (bus.inst_data !== 32'h1100_000C) $display("[TB] FAIL hold_data%0d: got %h want 1100000c", i, bus.inst_data); else n_pass++;
            n_checks++; if (bus.imem_req_valid !== 1'b0) $display("[TB] FAIL hold_req%0d: got %b want 0", i, bus.imem_req_valid); else n_pass++;
            n_checks++; if (current_pc !== 32'h0100_0010) $display("[TB] FAIL hold_cur_pc%0d: got %h want 01000010", i, current_pc); else n_pass++;
        end
        bus.inst_ready = 1'b1;
        tick();
        n_checks++; if (bus.inst_valid !== 1'b0) $display("[TB] FAIL drain_valid: got %b want 0", bus.inst_valid); else n_pass++;
        n_checks++; if (bus.imem_req_valid !== 1'b1) $display("[TB] FAIL drain_req: got %b want 1", bus.imem_req_valid); else n_pass++;
        n_checks++; if (bus.imem_req_addr !== 32'h0100_0010) $display("[TB] FAIL drain_addr: got %h want 01000010", bus.imem_req_addr); else n_pass++;
    endtask

    task automatic test_redirect_wait();
        int k;
        logic saw_stale;
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0100_0100;
        #1;
        n_checks++; if (next_pc !== 32'h0100_0100) $display("[TB] FAIL rw_next_pc: got %h want 01000100", next_pc); else n_pass++;
        tick();
        bus.redirect_valid = 1'b0;
        n_checks++; if (current_pc !== 32'h0100_0100) $display("[TB] FAIL rw_cur_pc: got %h want 01000100", current_pc); else n_pass++;
        n_checks++; if (bus.imem_req_valid !== 1'b0) $display("[TB] FAIL rw_req_valid: got %b want 0", bus.imem_req_valid); else n_pass++;
        saw_stale = 1'b0;
        k = 0;
        while (!bus.imem_req_valid && k < 20) begin
            if (bus.inst_valid) saw_stale = 1'b1;
            tick();
            k++;
        end
        n_checks++; if (bus.imem_req_addr !== 32'h0100_0100) $display("[TB] FAIL rw_refetch_addr: got %h want 01000100", bus.imem_req_addr); else n_pass++;
        k = 0;
        while (!bus.inst_valid && k < 20) begin
            tick();
            k++;
        end
        n_checks++; if (saw_stale !== 1'b0) $display("[TB] FAIL rw_stale: got %b want 0", saw_stale); else n_pass++;
        n_checks++; if (bus.inst_pc !== 32'h0100_0100) $display("[TB] FAIL rw_inst_pc: got %h want 01000100", bus.inst_pc); else n_pass++;
        n_checks++; if (bus.inst_data !== 32'h1100_0100) $display("[TB] FAIL rw_inst_data: got %h want 11000100", bus.inst_data); else n_pass++;
    endtask

    task automatic test_redirect_hold();
        int k;
        mem_lat = 1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0100_0200;
        tick();
        bus.redirect_valid = 1'b0;
        n_checks++; if (bus.inst_valid !== 1'b0) $display("[TB] FAIL rh_valid: got %b want 0", bus.inst_valid); else n_pass++;
        n_checks++; if (bus.imem_req_valid !== 1'b1) $display("[TB] FAIL rh_req: got %b want 1", bus.imem_req_valid); else n_pass++;
        n_checks++; if (bus.imem_req_addr !== 32'h0100_0200) $display("[TB] FAIL rh_addr: got %h want 01000200", bus.imem_req_addr); else n_pass++;
        n_checks++; if (misalign_err !== 1'b0) $display("[TB] FAIL rh_misalign: got %b want 0", misalign_err); else n_pass++;
        k = 0;
        while (!bus.inst_valid && k < 20) begin
            tick();
            k++;
        end
        n_checks++; if (bus.inst_pc !== 32'h0100_0200) $display("[TB] FAIL rh_inst_pc: got %h want 01000200", bus.inst_pc); else n_pass++;
        n_checks++; if (bus.inst_data !== 32'h1100_0200) $display("[TB] FAIL rh_inst_data: got %h want 11000200", bus.inst_data); else n_pass++;
    endtask

    task automatic test_misalign();
        int k;
        tick();
        n_checks++; if (bus.imem_req_addr !== 32'h0100_0204 || bus.imem_req_ready !== 1'b1) $display("[TB] FAIL ma_pre: got addr=%h ready=%b want 01000204/1", bus.imem_req_addr, bus.imem_req_ready); else n_pass++;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0100_0102;
        #1;
        n_checks++; if (next_pc !== 32'h0100_0100) $display("[TB] FAIL ma_next_pc: got %h want 01000100", next_pc); else n_pass++;
        tick();
        bus.redirect_valid = 1'b0;
        n_checks++; if (misalign_err !== 1'b1) $display("[TB] FAIL ma_pulse: got %b want 1", misalign_err); else n_pass++;
        n_checks++; if (current_pc !== 32'h0100_0100) $display("[TB] FAIL ma_cur_pc: got %h want 01000100", current_pc); else n_pass++;
        n_checks++; if (bus.imem_req_valid !== 1'b0) $display("[TB] FAIL ma_req: got %b want 0", bus.imem_req_valid); else n_pass++;
        tick();
        n_checks++; if (misalign_err !== 1'b0) $display("[TB] FAIL ma_pulse_end: got %b want 0", misalign_err); else n_pass++;
        k = 0;
        while (!bus.inst_valid && k < 20) begin
            tick();
            k++;
        end
        n_checks++; if (bus.inst_pc !== 32'h0100_0100) $display("[TB] FAIL ma_inst_pc: got %h want 01000100", bus.inst_pc); else n_pass++;
        n_checks++; if (bus.inst_data !== 32'h1100_0100) $display("[TB] FAIL ma_inst_data: got %h want 11000100", bus.inst_data); else n_pass++;
    endtask

    task automatic test_wrap();
        int k;
        logic        seen_rsp;
        logic [31:0] np_at_rsp;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        n_checks++; if (bus.imem_req_addr !== 32'hFFFF_FFFC) $display("[TB] FAIL wrap_addr: got %h want fffffffc", bus.imem_req_addr); else n_pass++;
        seen_rsp = 1'b0;
        np_at_rsp = 32'h0;
        k = 0;
        while (!bus.inst_valid && k < 20) begin
            if (bus.imem_rsp_valid && !seen_rsp) begin
                seen_rsp = 1'b1;
                np_at_rsp = next_pc;
            end
            tick();
            k++;
        end
        n_checks++; if (seen_rsp !== 1'b1 || np_at_rsp !== 32'h0) $display("[TB] FAIL wrap_next_pc: got %h (seen=%b) want 00000000", np_at_rsp, seen_rsp); else n_pass++;
        n_checks++; if (bus.inst_pc !== 32'hFFFF_FFFC) $display("[TB] FAIL wrap_inst_pc: got %h want fffffffc", bus.inst_pc); else n_pass++;
        n_checks++; if (bus.inst_data !== 32'h0FFF_FFFC) $display("[TB] FAIL wrap_inst_data: got %h want 0ffffffc", bus.inst_data); else n_pass++;
        n_checks++; if (current_pc !== 32'h0) $display("[TB] FAIL wrap_cur_pc: got %h want 00000000", current_pc); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int k;
        mem_lat = 3;
        tick();
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0100_0300;
        tick();
        bus.redirect_valid = 1'b0;
        reset = 1'b1;
        tick();
        n_checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) $display("[TB] FAIL mid_rst_outputs: got valid=%b req=%b want 0/0", bus.inst_valid, bus.imem_req_valid); else n_pass++;
        n_checks++; if (next_pc !== 32'h0100_0000) $display("[TB] FAIL mid_rst_next_pc: got %h want 01000000", next_pc); else n_pass++;
        tick();
        reset = 1'b0;
        #1;
        n_checks++; if (current_pc !== 32'h0100_0000 || bus.imem_req_valid !== 1'b1) $display("[TB] FAIL mid_rel: got pc=%h req=%b want 01000000/1", current_pc, bus.imem_req_valid); else n_pass++;
        k = 0;
        do begin
            tick();
            k++;
        end while (!bus.inst_valid && k < 20);
        n_checks++; if (k !== 4) $display("[TB] FAIL mid_latency: got %0d cycles want 4", k); else n_pass++;
        n_checks++; if (bus.inst_pc !== 32'h0100_0000) $display("[TB] FAIL mid_inst_pc: got %h want 01000000", bus.inst_pc); else n_pass++;
        n_checks++; if (bus.inst_data !== 32'h1100_0000) $display("[TB] FAIL mid_inst_data: got %h want 11000000", bus.inst_data); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_latency();
        test_hold();
        test_redirect_wait();
        test_redirect_hold();
        test_misalign();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
